// File: rtl/breakout_bounce_arbiter_if.sv
// rtl/breakout_bounce_arbiter_if.sv - column request / bounce command bundle for the bounce arbiter
interface breakout_bounce_arbiter_if #(
  parameter int NUM_COLS = 6
);
  logic                  frame_tick;
  logic [NUM_COLS-1:0]   req_u;
  logic [NUM_COLS-1:0]   req_d;
  logic [NUM_COLS-1:0]   req_l;
  logic [NUM_COLS-1:0]   req_r;
  logic [5*NUM_COLS-1:0] col_count;
  logic                  bounce_valid;
  logic [1:0]            bounce_dir;
  logic [2:0]            bounce_col;
  logic                  busy;
  logic [7:0]            blocks_cleared;
  logic                  level_clear;
  logic [15:0]           hit_total;

  // Columns and frame timing side
  modport master (
    output frame_tick, req_u, req_d, req_l, req_r, col_count,
    input  bounce_valid, bounce_dir, bounce_col, busy, blocks_cleared, level_clear, hit_total
  );

  // Arbiter side
  modport slave (
    input  frame_tick, req_u, req_d, req_l, req_r, col_count,
    output bounce_valid, bounce_dir, bounce_col, busy, blocks_cleared, level_clear, hit_total
  );
endinterface

// File: rtl/breakout_bounce_arbiter.sv
// rtl/breakout_bounce_arbiter.sv - round-robin bounce arbiter with frame-tick cooldown; BREAKOUT_HIT_STATS_EN enables hit_total
module breakout_bounce_arbiter #(
  parameter int NUM_COLS       = 6,
  parameter int BLOCKS_PER_COL = 8,
  parameter int COOLDOWN_TICKS = 2
) (
  input logic                      clk,
  input logic                      reset,
  breakout_bounce_arbiter_if.slave bus
);
  localparam logic [7:0] CLEAR_TARGET  = 8'(NUM_COLS * BLOCKS_PER_COL);
  localparam logic [3:0] COOLDOWN_INIT = 4'(COOLDOWN_TICKS);
  localparam logic [2:0] LAST_COL      = 3'(NUM_COLS - 1);
  localparam logic [3:0] NUM_COLS_W    = 4'(NUM_COLS);

  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

  state_t              state;
  logic [2:0]          rr_ptr;
  logic [3:0]          cooldown_cnt;
  logic [NUM_COLS-1:0] col_req;
  logic                any_req;
  logic [2:0]          pick_col;
  logic [1:0]          pick_dir;
  logic [7:0]          count_sum;

  assign col_req = bus.req_u | bus.req_d | bus.req_l | bus.req_r;
  assign any_req = |col_req;

  // Pick the first requesting column at or above rr_ptr (wrapping), then its direction, vertical first
  always_comb begin
    logic [3:0] idx;
    logic       found;
    idx      = '0;
    found    = 1'b0;
    pick_col = '0;
    pick_dir = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= NUM_COLS_W) idx = idx - NUM_COLS_W;
      if (!found && col_req[idx[2:0]]) begin
        found    = 1'b1;
        pick_col = idx[2:0];
      end
    end
    if (bus.req_d[pick_col])      pick_dir = 2'd1;
    else if (bus.req_u[pick_col]) pick_dir = 2'd0;
    else if (bus.req_l[pick_col]) pick_dir = 2'd2;
    else                          pick_dir = 2'd3;
  end

  // Total of all per-column hit counts, zero-extended to 8 bits
  always_comb begin
    count_sum = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      count_sum = count_sum + {3'b000, bus.col_count[5*i +: 5]};
    end
  end

  // Bounce FSM with registered command, busy, score total and sticky level-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      cooldown_cnt       <= '0;
      bus.bounce_valid   <= 1'b0;
      bus.bounce_dir     <= '0;
      bus.bounce_col     <= '0;
      bus.busy           <= 1'b0;
      bus.blocks_cleared <= '0;
      bus.level_clear    <= 1'b0;
    end else begin
      bus.blocks_cleared <= count_sum;
      if (bus.blocks_cleared == CLEAR_TARGET) bus.level_clear <= 1'b1;

      case (state)
        IDLE: begin
          // Once the level is clear the arbiter parks here for good
          if (any_req && !bus.level_clear) begin
            state            <= GRANT;
            bus.bounce_valid <= 1'b1;
            bus.bounce_dir   <= pick_dir;
            bus.bounce_col   <= pick_col;
          end
        end
        GRANT: begin
          bus.bounce_valid <= 1'b0;
          rr_ptr           <= (bus.bounce_col == LAST_COL) ? 3'd0 : bus.bounce_col + 3'd1;
          if (COOLDOWN_TICKS == 0) begin
            state <= IDLE;
          end else begin
            cooldown_cnt <= COOLDOWN_INIT;
            bus.busy     <= 1'b1;
            state        <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          // Requests seen here are simply ignored; only frame ticks matter
          if (bus.frame_tick) begin
            if (cooldown_cnt <= 4'd1) begin
              cooldown_cnt <= '0;
              bus.busy     <= 1'b0;
              state        <= IDLE;
            end else begin
              cooldown_cnt <= cooldown_cnt - 4'd1;
            end
          end
        end
        default: begin
          state            <= IDLE;
          bus.bounce_valid <= 1'b0;
          bus.busy         <= 1'b0;
        end
      endcase
    end
  end

`ifdef BREAKOUT_HIT_STATS_EN
  // Saturating count of grant cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.hit_total <= '0;
    end else if (state == GRANT && bus.hit_total != 16'hFFFF) begin
      bus.hit_total <= bus.hit_total + 16'd1;
    end
  end
`else
  assign bus.hit_total = 16'h0000;
`endif
endmodule

// File: tb/tb_breakout_bounce_arbiter.sv
// tb/tb_breakout_bounce_arbiter.sv - self-checking bench for breakout_bounce_arbiter
module tb_breakout_bounce_arbiter;
  localparam int N   = 6;
  localparam int BPC = 8;
  localparam int CD  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  breakout_bounce_arbiter_if #(.NUM_COLS(N)) bus ();

  breakout_bounce_arbiter #(
    .NUM_COLS(N), .BLOCKS_PER_COL(BPC), .COOLDOWN_TICKS(CD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bounce, remaining lockout ticks, next column to favour
  bit m_valid;
  int m_dir, m_col, m_rr, m_lock, m_bc, m_hits;
  bit m_lc;

  logic [31:0] got;
  assign got = {bus.bounce_valid, bus.bounce_dir, bus.bounce_col, bus.busy,
                bus.blocks_cleared, bus.level_clear, bus.hit_total};

  function automatic logic [31:0] expected();
    logic [15:0] h;
`ifdef BREAKOUT_HIT_STATS_EN
    h = 16'(m_hits);
`else
    h = 16'h0000;
`endif
    return {m_valid, 2'(m_dir), 3'(m_col), (m_lock > 0), 8'(m_bc), m_lc, h};
  endfunction

  task automatic model_step();
    int  sum;
    bit  found;
    int  c;
    if (reset) begin
      m_valid = 0; m_dir = 0; m_col = 0; m_rr = 0;
      m_lock = 0; m_bc = 0; m_lc = 0; m_hits = 0;
      return;
    end
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(bus.col_count[5*i +: 5]);
    if (m_valid) begin
      m_rr = (m_col + 1) % N;
      if (m_hits < 65535) m_hits++;
      m_lock  = CD;
      m_valid = 0;
    end else if (m_lock > 0) begin
      if (bus.frame_tick) m_lock--;
    end else if (!m_lc) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!found && (bus.req_u[c] | bus.req_d[c] | bus.req_l[c] | bus.req_r[c])) begin
          found = 1;
          m_col = c;
          m_dir = bus.req_d[c] ? 1 : bus.req_u[c] ? 0 : bus.req_l[c] ? 2 : 3;
          m_valid = 1;
        end
      end
    end
    if (m_bc == N * BPC) m_lc = 1;
    m_bc = sum;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_u = '0; bus.req_d = '0; bus.req_l = '0; bus.req_r = '0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic drain();
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 20 && (m_lock > 0 || m_valid); i++) tick();
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.col_count = 30'($urandom);
    tick(); tick();
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_state got=%h exp=%h", got, 32'h0); end
    checks++;
    if (got !== expected()) begin errors++; $display("FAIL reset_model got=%h exp=%h", got, expected()); end
    reset = 1'b0;
    bus.col_count = '0;
    tick();
  endtask

  task automatic test_single_bounce();
    bus.req_d[2] = 1'b1;
    tick();
    bus.req_d[2] = 1'b0;
    checks++;
    if ({bus.bounce_valid, bus.bounce_dir, bus.bounce_col} !== {1'b1, 2'd1, 3'd2}) begin
      errors++; $display("FAIL single_cmd got=%b/%0d/%0d exp=1/1/2", bus.bounce_valid, bus.bounce_dir, bus.bounce_col);
    end
    tick();
    checks++;
    if ({bus.bounce_valid, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL single_busy_rise got=%b exp=01", {bus.bounce_valid, bus.busy});
    end
    bus.frame_tick = 1'b1; tick(); bus.frame_tick = 1'b0;
    tick(); tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_one_tick got=%b exp=1", bus.busy); end
    bus.frame_tick = 1'b1; tick(); bus.frame_tick = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b exp=0", bus.busy); end
    checks++;
    if (got !== expected()) begin errors++; $display("FAIL single_model got=%h exp=%h", got, expected()); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [4:0] second;
    reset = 1'b1; tick(); reset = 1'b0;
    bus.req_l[0] = 1'b1;
    bus.req_u[3] = 1'b1;
    tick();
    checks++;
    if ({bus.bounce_valid, bus.bounce_dir, bus.bounce_col} !== {1'b1, 2'd2, 3'd0}) begin
      errors++; $display("FAIL rr_first got=%b/%0d/%0d exp=1/2/0", bus.bounce_valid, bus.bounce_dir, bus.bounce_col);
    end
    bus.frame_tick = 1'b1;
    n = 0;
    second = '0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      tick();
      checks++;
      if (got !== expected()) begin errors++; $display("FAIL rr_model got=%h exp=%h", got, expected()); end
      if (bus.bounce_valid) begin n++; second = {bus.bounce_dir, bus.bounce_col}; end
    end
    checks++;
    if (n != 1 || second !== {2'd0, 3'd3}) begin
      errors++; $display("FAIL rr_second got=n%0d dir%0d col%0d exp=n1 dir0 col3", n, second[4:3], second[2:0]);
    end
    clear_inputs();
    drain();
  endtask

  task automatic test_priority();
    bus.req_l[1] = 1'b1;
    bus.req_d[1] = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if ({bus.bounce_valid, bus.bounce_dir, bus.bounce_col} !== {1'b1, 2'd1, 3'd1}) begin
      errors++; $display("FAIL priority got=%b/%0d/%0d exp=1/1/1", bus.bounce_valid, bus.bounce_dir, bus.bounce_col);
    end
    drain();
  endtask

  task automatic test_drop();
    int n;
    logic [4:0] seen;
    bus.req_d[0] = 1'b1; tick(); bus.req_d[0] = 1'b0;
    tick();
    bus.req_r[4] = 1'b1; tick(); bus.req_r[4] = 1'b0;
    bus.frame_tick = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.bounce_valid) n++;
      checks++;
      if (got !== expected()) begin errors++; $display("FAIL drop_model got=%h exp=%h", got, expected()); end
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL drop_released got=%0d bounces exp=0", n); end
    bus.frame_tick = 1'b0;
    bus.req_d[0] = 1'b1; tick(); bus.req_d[0] = 1'b0;
    tick();
    bus.req_r[4] = 1'b1;
    bus.frame_tick = 1'b1;
    n = 0;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.bounce_valid) begin n++; seen = {bus.bounce_dir, bus.bounce_col}; bus.req_r[4] = 1'b0; end
    end
    checks++;
    if (n != 1 || seen !== {2'd3, 3'd4}) begin
      errors++; $display("FAIL drop_held got=n%0d dir%0d col%0d exp=n1 dir3 col4", n, seen[4:3], seen[2:0]);
    end
    clear_inputs();
    drain();
  endtask

  task automatic test_level_clear();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    bus.col_count = {N{5'd8}};
    tick();
    checks++;
    if ({bus.blocks_cleared, bus.level_clear} !== {8'd48, 1'b0}) begin
      errors++; $display("FAIL lc_sum got=%0d/%b exp=48/0", bus.blocks_cleared, bus.level_clear);
    end
    tick();
    checks++;
    if (bus.level_clear !== 1'b1) begin errors++; $display("FAIL lc_set got=%b exp=1", bus.level_clear); end
    bus.req_u[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.bounce_valid) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL lc_no_grant got=%0d bounces exp=0", n); end
    reset = 1'b1; tick();
    checks++;
    if ({bus.level_clear, bus.blocks_cleared} !== 9'd0) begin
      errors++; $display("FAIL lc_reset got=%b/%0d exp=0/0", bus.level_clear, bus.blocks_cleared);
    end
    reset = 1'b0;
    bus.req_u[0] = 1'b0;
    bus.col_count = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    tick();
    checks++;
    if (bus.blocks_cleared !== 8'd21) begin errors++; $display("FAIL lc_after_reset got=%0d exp=21", bus.blocks_cleared); end
    checks++;
    if (got !== expected()) begin errors++; $display("FAIL lc_model got=%h exp=%h", got, expected()); end
    bus.col_count = '0;
    tick();
  endtask

  task automatic test_stats();
    logic [15:0] exp_hits;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      bus.req_u[g] = 1'b1; tick(); bus.req_u[g] = 1'b0;
      drain();
    end
`ifdef BREAKOUT_HIT_STATS_EN
    exp_hits = 16'd3;
`else
    exp_hits = 16'd0;
`endif
    checks++;
    if (bus.hit_total !== exp_hits) begin errors++; $display("FAIL stats_count got=%0d exp=%0d", bus.hit_total, exp_hits); end
    bus.req_l[5] = 1'b1; tick(); bus.req_l[5] = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({bus.bounce_valid, bus.busy, bus.hit_total} !== 18'd0) begin
      errors++; $display("FAIL stats_reset got=%b/%b/%0d exp=0/0/0", bus.bounce_valid, bus.busy, bus.hit_total);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset = ($urandom_range(99) == 0);
      for (int i = 0; i < N; i++) begin
        bus.req_u[i] = ($urandom_range(11) == 0);
        bus.req_d[i] = ($urandom_range(11) == 0);
        bus.req_l[i] = ($urandom_range(11) == 0);
        bus.req_r[i] = ($urandom_range(11) == 0);
      end
      bus.frame_tick = ($urandom_range(2) == 0);
      if ($urandom_range(15) == 0) begin
        for (int i = 0; i < N; i++) bus.col_count[5*i +: 5] = 5'($urandom_range(7));
      end
      tick();
      checks++;
      if (got !== expected()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, expected()); end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    bus.col_count = '0;
    test_reset();
    test_single_bounce();
    test_round_robin();
    test_priority();
    test_drop();
    test_level_clear();
    test_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
